tcbm_device_port: RTL

// Drive-side end of the TCBM link: answers the 4-phase DAV/ACK handshake that the host-side 6523 port
// (port A data, port B STATUS0/1, port C7 DAV out, port C6 ACK in) initiates. Each transaction is a

---
 rtl/tcbm_device_port.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/tcbm_device_port.sv
// tcbm_device_port
// Drive-side end of the TCBM link. Answers the host's 4-phase DAV/ACK
// handshake: each transaction is a command byte followed by one data byte.
//   0x81 : host writes a data byte    -> rx stream, rx_cmd=0
//   0x83 : host writes a command byte -> rx stream, rx_cmd=1
//   0x82 : host reads a byte          <- tx stream (or timeout status)
// Ports:
//   clock, _reset          system clock, async active-low reset
//   dav (in, async)        host DAV, active low
//   ack (out)              device ACK, active low
//   data_in/data_out/data_oe  TCBM data pins (sampled / driven / enable)
//   status[1:0]            00 ok, 01 timeout, 11 EOI
//   rx_data/rx_cmd/rx_valid/rx_ready   host->drive byte stream
//   tx_data/tx_eoi/tx_valid/tx_ready   drive->host byte stream
//   bad_cmd                one-cycle pulse on an unknown command byte
module tcbm_device_port #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 4095
) (
  input  logic       clock,
  input  logic       _reset,
  input  logic       dav,
  output logic       ack,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic [1:0] status,
  output logic [7:0] rx_data,
  output logic       rx_cmd,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_eoi,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       bad_cmd
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  localparam logic [7:0] CMD_WR_DATA = 8'h81;
  localparam logic [7:0] CMD_READ    = 8'h82;
  localparam logic [7:0] CMD_WR_CMD  = 8'h83;

  typedef enum logic [2:0] {
    IDLE,
    CMD_REL,
    DATA_WAIT,
    DATA_ACK,
    DATA_REL
  } state_t;

  state_t          state;
  logic [7:0]      cmd;
  logic [CW-1:0]   tcnt;
  logic [SYNC_STAGES-1:0] dav_sync;
  logic            davs;

  // Synchroniser presets to 1 so a reset never looks like an asserted DAV.
  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) dav_sync <= '1;
    else         dav_sync <= {dav_sync[SYNC_STAGES-2:0], dav};
  end

  assign davs = dav_sync[SYNC_STAGES-1];

  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      state    <= IDLE;
      cmd      <= '0;
      tcnt     <= '0;
      ack      <= 1'b1;
      data_out <= '0;
      data_oe  <= 1'b0;
      status   <= 2'b00;
      rx_data  <= '0;
      rx_cmd   <= 1'b0;
      rx_valid <= 1'b0;
      tx_ready <= 1'b0;
      bad_cmd  <= 1'b0;
    end else begin
      tx_ready <= 1'b0;
      bad_cmd  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!davs) begin
            cmd   <= data_in;
            ack   <= 1'b0;
            state <= CMD_REL;
          end
        end

        CMD_REL: begin
          if (davs) begin
            ack <= 1'b1;
            if (cmd == CMD_WR_DATA || cmd == CMD_WR_CMD || cmd == CMD_READ) begin
              state <= DATA_WAIT;
            end else begin
              bad_cmd <= 1'b1;
              state   <= IDLE;
            end
          end
        end

        DATA_WAIT: begin
          if (!davs) begin
            tcnt  <= '0;
            state <= DATA_ACK;
            if (cmd == CMD_READ) begin
              data_oe <= 1'b1;
            end else begin
              rx_data  <= data_in;
              rx_cmd   <= (cmd == CMD_WR_CMD);
              rx_valid <= 1'b1;
            end
          end
        end

        // DAV is deliberately ignored here: an aborting host still gets
        // exactly one completion, and DATA_REL then closes immediately.
        DATA_ACK: begin
          if (cmd == CMD_READ) begin
            if (tx_valid) begin
              data_out <= tx_data;
              status   <= tx_eoi ? 2'b11 : 2'b00;
              tx_ready <= 1'b1;
              ack      <= 1'b0;
              state    <= DATA_REL;
            end else if (tcnt == TMAX) begin
              data_out <= '0;
              status   <= 2'b01;
              ack      <= 1'b0;
              state    <= DATA_REL;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
            status   <= 2'b00;
            ack      <= 1'b0;
            state    <= DATA_REL;
          end
        end

        DATA_REL: begin
          if (davs) begin
            ack     <= 1'b1;
            data_oe <= 1'b0;
            state   <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
